// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/opcode widths, the eight opcode encodings and a
// legality check. Used by the ALU and by the UART command front-end.
package alu_pkg;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;

    // True when the opcode is one the ALU implements.
    function automatic logic is_legal_op(input logic [NB_OP-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_if_timer.sv
// Inter-byte timeout counter for alu_uart_if (instantiated only when
// ALU_IF_TIMEOUT_EN is defined). Counts while enabled, clears on a byte or
// when disabled, and flags expiry on the last count unless a byte arrives.
module alu_if_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count idle cycles while waiting inside a frame; restart on each byte.
    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A byte in the expiry cycle wins over the timeout.
    assign expired = en && !clr && (count == LAST);

endmodule

// File: rtl/alu_uart_if.sv
// UART-to-ALU command front-end. Collects a frame {A, B, opcode} from the RX
// byte stream, rejects illegal opcodes, pulses the ALU, and sends the one-byte
// result to the TX core. Optional macro ALU_IF_TIMEOUT_EN adds an inter-byte
// timeout that discards partial frames; without it o_timeout is tied 0.
//
// Handshakes: i_rx_done / i_tx_done / o_tx_start / o_alu_valid are one-cycle
// pulses with no back-pressure. o_tx_data is valid from o_tx_start until
// i_tx_done; ALU operands stay stable until the next frame overwrites them.
module alu_uart_if
    import alu_pkg::*;
#(
    parameter int NB_DATA        = alu_pkg::NB_DATA,
    parameter int NB_OP          = alu_pkg::NB_OP,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    output logic               o_alu_valid,
    output logic [NB_DATA-1:0] o_alu_datoA,
    output logic [NB_DATA-1:0] o_alu_datoB,
    output logic [NB_OP-1:0]   o_alu_operation,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_err,
    output logic               o_timeout
);

    if (NB_DATA != 8) begin : g_bad_width
        $error("alu_uart_if: NB_DATA must be 8 (one UART byte)");
    end
    if (NB_OP != alu_pkg::NB_OP) begin : g_bad_op
        $error("alu_uart_if: NB_OP must match the ALU opcode width");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("alu_uart_if: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [NB_DATA-1:0] a_nx, b_nx;
    logic [NB_OP-1:0]   op_nx;
    logic [7:0]         tx_data_nx;
    logic               alu_valid_nx, tx_start_nx, err_nx, timeout_nx;
    logic               expired;

`ifdef ALU_IF_TIMEOUT_EN
    alu_if_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (i_clk),
        .rst    (i_rst),
        .clr    (i_rx_done),
        .en     ((state == WAIT_B) || (state == WAIT_OP)),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    // State register and registered outputs; reset abandons any frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= WAIT_A;
            o_alu_datoA     <= '0;
            o_alu_datoB     <= '0;
            o_alu_operation <= '0;
            o_tx_data       <= '0;
            o_alu_valid     <= 1'b0;
            o_tx_start      <= 1'b0;
            o_err           <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            state           <= state_nx;
            o_alu_datoA     <= a_nx;
            o_alu_datoB     <= b_nx;
            o_alu_operation <= op_nx;
            o_tx_data       <= tx_data_nx;
            o_alu_valid     <= alu_valid_nx;
            o_tx_start      <= tx_start_nx;
            o_err           <= err_nx;
            o_timeout       <= timeout_nx;
        end
    end

    // Next-state and next-output decode; bytes outside WAIT_A/B/OP are dropped.
    always_comb begin
        state_nx     = state;
        a_nx         = o_alu_datoA;
        b_nx         = o_alu_datoB;
        op_nx        = o_alu_operation;
        tx_data_nx   = o_tx_data;
        alu_valid_nx = 1'b0;
        tx_start_nx  = 1'b0;
        err_nx       = 1'b0;
        timeout_nx   = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    a_nx     = i_rx_data;
                    state_nx = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    b_nx     = i_rx_data;
                    state_nx = WAIT_OP;
                end else if (expired) begin
                    timeout_nx = 1'b1;
                    state_nx   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    op_nx = i_rx_data[NB_OP-1:0];
                    if (is_legal_op(i_rx_data[NB_OP-1:0])) begin
                        alu_valid_nx = 1'b1;
                        state_nx     = EXEC;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = WAIT_A;
                    end
                end else if (expired) begin
                    timeout_nx = 1'b1;
                    state_nx   = WAIT_A;
                end
            end
            EXEC: begin
                tx_data_nx  = i_alu_result;
                tx_start_nx = 1'b1;
                state_nx    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_nx = WAIT_A;
                end
            end
            default: state_nx = WAIT_A;
        endcase
    end

endmodule

// File: doc/alu_uart_if.md
Name: alu_uart_if

Overview:
Command front-end that feeds the 8-bit ALU from a byte-stream receiver and returns the result to a byte-stream transmitter. It collects a three-byte frame (operand A, operand B, opcode) and checks the opcode. It drives the ALU operand and operation inputs, pulses the ALU valid, captures the ALU result and sends it as one byte. It sits between the UART RX/TX cores and the ALU, acting as the initiator on the ALU's valid/operand/operation interface.

Parameters:
NB_DATA, 8, operand/result width; must equal 8 (one UART byte), elaboration error otherwise
NB_OP, 6, opcode width driven to the ALU
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clocks (used only with ALU_IF_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_rx_data  in  8  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse: new byte on i_rx_data
i_tx_done  in  1  one-cycle pulse: transmitter finished the byte
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
o_tx_data  out  8  byte to transmit, held stable from o_tx_start until i_tx_done
o_alu_valid  out  1  one-cycle pulse to ALU valid
o_alu_datoA  out  NB_DATA  operand A register
o_alu_datoB  out  NB_DATA  operand B register
o_alu_operation  out  NB_OP  opcode register
i_alu_result  in  NB_DATA  combinational ALU result
o_err  out  1  one-cycle pulse: illegal opcode frame discarded
o_timeout  out  1  one-cycle pulse: partial frame discarded by timeout (constant 0 without macro)

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset: state=WAIT_A; all outputs 0; A/B/OP registers 0; timeout counter 0. A reset in any state abandons the frame the same cycle, including mid-transmit; no o_tx_start follows.
- Registers update only on i_clk; all outputs are registered except none (fully registered).
- States and transitions:
  - WAIT_A: on i_rx_done, A<=i_rx_data -> WAIT_B.
  - WAIT_B: on i_rx_done, B<=i_rx_data -> WAIT_OP.
  - WAIT_OP: on i_rx_done, OP<=i_rx_data[NB_OP-1:0]; upper bits ignored.
    - Opcode legal (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111) -> EXEC.
    - Otherwise o_err=1 for one cycle -> WAIT_A; ALU not pulsed, nothing transmitted.
  - EXEC (1 cycle): o_alu_valid=1; o_tx_data<=i_alu_result; o_tx_start=1 next cycle -> WAIT_TX.
  - WAIT_TX: hold o_tx_data; on i_tx_done -> WAIT_A.
- Latency: o_alu_valid asserts 1 cycle after the opcode i_rx_done. o_tx_start asserts 2 cycles after it.
- o_alu_datoA/B/operation are held after EXEC until overwritten by the next frame (ALU inputs stay stable).
- i_rx_done during EXEC or WAIT_TX: byte dropped; the frame is not affected.
- i_tx_done outside WAIT_TX: ignored.
- i_rx_done and i_tx_done in the same WAIT_TX cycle: transition to WAIT_A; the rx byte is dropped.

Optional Feature:
- ALU_IF_TIMEOUT_EN defined: a counter clears on every i_rx_done and increments in WAIT_B and WAIT_OP. Reaching TIMEOUT_CYCLES-1 without a byte pulses o_timeout for one cycle, returns to WAIT_A and discards the partial frame. An i_rx_done in the same cycle as the timeout wins: the byte is accepted and no timeout occurs.
- ALU_IF_TIMEOUT_EN undefined: no counter; o_timeout tied 0; the block waits indefinitely.

Decomposition:
- Shared package alu_pkg: NB_DATA/NB_OP constants, the eight opcode localparams, and an is_legal_op function; these are shared with the ALU.
- State encoding is a localparam enum local to this module.
- No sub-module, except the optional timeout counter, which may be a small alu_if_timer sub-module.

Test Plan:
- Frames 05,03,20 -> o_alu_valid 1 cycle after the opcode byte with A=05/B=03/OP=100000; o_tx_start with o_tx_data=08; i_tx_done returns to WAIT_A.
- Frames F0,04,03 (SRA) -> 0xFF sent. Frames F0,04,02 (SRL) -> 0x0F sent.
- Frames 01,02,3F (illegal) -> o_err pulse; no o_alu_valid or o_tx_start. Next frame 07,01,22 -> 0x06 sent.
- Extra byte AA during WAIT_TX -> dropped. Next frame 0C,0A,24 -> 0x08 sent.
- i_rst asserted in WAIT_OP and again in WAIT_TX -> all outputs 0 the next cycle; no o_tx_start; a full frame afterwards works.
- With ALU_IF_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte 05, then silence -> o_timeout after 16 cycles. Then 02,03,20 -> 0x05 sent (old A discarded).
